// File: rtl/col_collision.sv
// Collision checker behind the column drawer: snapshots bird and openings on a
// check strobe, tests the four columns one per cycle, then reports hit and score.
module col_collision #(
  parameter int COL1_X     = 32,
  parameter int COL2_X     = 64,
  parameter int COL3_X     = 96,
  parameter int COL4_X     = 128,
  parameter int COL_WIDTH  = 2,
  parameter int UP_WIDTH   = 11,
  parameter int DOWN_WIDTH = 34,
  parameter int BIRD_W     = 2,
  parameter int BIRD_H     = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       done_col,
  input  logic [6:0] col1_op,
  input  logic [6:0] col2_op,
  input  logic [6:0] col3_op,
  input  logic [6:0] col4_op,
  input  logic       check,
  input  logic [7:0] bird_x,
  input  logic [6:0] bird_y,
  output logic       busy,
  output logic       result_valid,
  output logic       hit,
  output logic [7:0] score,
  output logic       game_over
);

  // state    | meaning
  // S_IDLE   | waiting for check with done_col
  // S_CHECK  | testing column k_q against the snapshot
  // S_REPORT | one-cycle result_valid, hit/score already updated
  // S_OVER   | sticky game over, left only through clr
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REPORT, S_OVER} state_t;

  localparam logic [8:0] C1_X  = 9'(COL1_X);
  localparam logic [8:0] C2_X  = 9'(COL2_X);
  localparam logic [8:0] C3_X  = 9'(COL3_X);
  localparam logic [8:0] C4_X  = 9'(COL4_X);
  localparam logic [8:0] C_W   = 9'(COL_WIDTH);
  localparam logic [8:0] UP_W  = 9'(UP_WIDTH);
  localparam logic [8:0] DN_W  = 9'(DOWN_WIDTH);
  localparam logic [8:0] B_W   = 9'(BIRD_W);
  localparam logic [8:0] B_H   = 9'(BIRD_H);

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [7:0]  bx_q, bx_d;
  logic [6:0]  by_q, by_d;
  logic [6:0]  op_q [4];
  logic [6:0]  op_d [4];
  logic        acc_q, acc_d;
  logic [2:0]  pass_q, pass_d;
  logic        hit_q, hit_d;
  logic [7:0]  score_q, score_d;

  logic [8:0]  col_x, x9, y9, op9, lo9, hi9, sum9;
  logic [6:0]  op_sel;
  logic        overlap, outside, hit_k, pass_k;

  // Geometry for the column currently indexed, all in 9 bits so nothing wraps.
  always_comb begin
    col_x = C1_X;
    unique case (k_q)
      2'd0: col_x = C1_X;
      2'd1: col_x = C2_X;
      2'd2: col_x = C3_X;
      2'd3: col_x = C4_X;
    endcase
    op_sel  = op_q[k_q];
    x9      = {1'b0, bx_q};
    y9      = {2'b00, by_q};
    op9     = {2'b00, op_sel};
    lo9     = (op9 >= UP_W) ? (op9 - UP_W) : 9'd0;
    hi9     = op9 + DN_W;
    overlap = (x9 + B_W - 9'd1 >= col_x) && (x9 <= col_x + C_W - 9'd1);
    outside = (y9 < lo9) || (y9 + B_H - 9'd1 > hi9);
    hit_k   = (op_sel != 7'd0) && overlap && outside;
    pass_k  = (op_sel != 7'd0) && (x9 == col_x + C_W);
    sum9    = {1'b0, score_q} + {6'b0, pass_q} + {8'b0, pass_k};
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      bx_q    <= 8'd0;
      by_q    <= 7'd0;
      for (int i = 0; i < 4; i++) op_q[i] <= 7'd0;
      acc_q   <= 1'b0;
      pass_q  <= 3'd0;
      hit_q   <= 1'b0;
      score_q <= 8'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      for (int i = 0; i < 4; i++) op_q[i] <= op_d[i];
      acc_q   <= acc_d;
      pass_q  <= pass_d;
      hit_q   <= hit_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    bx_d         = bx_q;
    by_d         = by_q;
    for (int i = 0; i < 4; i++) op_d[i] = op_q[i];
    acc_d        = acc_q;
    pass_d       = pass_q;
    hit_d        = hit_q;
    score_d      = score_q;
    busy         = 1'b0;
    result_valid = 1'b0;
    game_over    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (check && done_col) begin
          bx_d    = bird_x;
          by_d    = bird_y;
          op_d[0] = col1_op;
          op_d[1] = col2_op;
          op_d[2] = col3_op;
          op_d[3] = col4_op;
          acc_d   = 1'b0;
          pass_d  = 3'd0;
          k_d     = 2'd0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        busy   = 1'b1;
        acc_d  = acc_q | hit_k;
        pass_d = pass_q + {2'b00, pass_k};
        k_d    = k_q + 2'd1;
        // Commit on the last column so hit/score are valid during result_valid.
        if (k_q == 2'd3) begin
          hit_d   = acc_q | hit_k;
          score_d = (sum9 > 9'd255) ? 8'd255 : sum9[7:0];
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        state_d      = hit_q ? S_OVER : S_IDLE;
      end
      S_OVER: begin
        game_over = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign hit   = hit_q;
  assign score = score_q;

endmodule

// File: tb/tb_col_collision.sv
// Directed bench for col_collision: a vector table of single checks plus
// hand-written sequences for game over, handshake, snapshot and reset corners.
module tb_col_collision;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       done_col = 1'b0;
  logic [6:0] col1_op = '0, col2_op = '0, col3_op = '0, col4_op = '0;
  logic       check = 1'b0;
  logic [7:0] bird_x = '0;
  logic [6:0] bird_y = '0;
  logic       busy, result_valid, hit, game_over;
  logic [7:0] score;

  int n_cmp = 0;
  int n_bad = 0;

  col_collision dut (
    .clk(clk), .clr(clr), .done_col(done_col),
    .col1_op(col1_op), .col2_op(col2_op), .col3_op(col3_op), .col4_op(col4_op),
    .check(check), .bird_x(bird_x), .bird_y(bird_y),
    .busy(busy), .result_valid(result_valid), .hit(hit), .score(score),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bx;
    logic [6:0] by;
    logic [6:0] op1, op2, op3, op4;
    logic       exp_hit;
    logic [7:0] exp_score;
  } vec_t;

  vec_t vecs [12];

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic [7:0] bx, input logic [6:0] by,
                            input logic [6:0] o1, input logic [6:0] o2,
                            input logic [6:0] o3, input logic [6:0] o4);
    bird_x = bx; bird_y = by;
    col1_op = o1; col2_op = o2; col3_op = o3; col4_op = o4;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
  endtask

  // One check pulse; verifies busy, the result_valid latency and its single pulse.
  task automatic run_check(input string tag);
    int lat;
    lat = -1;
    @(negedge clk);
    done_col = 1'b1;
    check = 1'b1;
    @(posedge clk);
    #1 check = 1'b0;
    cmp({tag, " busy_after_edge0"}, int'(busy), 1);
    for (int n = 1; n <= 10 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (result_valid) lat = n;
    end
    cmp({tag, " result_latency"}, lat, 4);
    @(posedge clk);
    #1;
    cmp({tag, " rv_single_pulse"}, int'(result_valid), 0);
    cmp({tag, " busy_released"}, int'(busy), 0);
  endtask

  // Pulses check and confirms the block never goes busy or reports.
  task automatic expect_ignored(input string tag);
    int seen;
    seen = 0;
    @(negedge clk);
    check = 1'b1;
    for (int n = 0; n < 7; n++) begin
      @(posedge clk);
      #1;
      if (busy || result_valid) seen++;
    end
    check = 1'b0;
    cmp({tag, " ignored_activity"}, seen, 0);
  endtask

  initial begin
    vecs[0]  = '{8'd10,  7'd50, 7'd20,  7'd40,  7'd60,  7'd80,  1'b0, 8'd0};
    vecs[1]  = '{8'd32,  7'd53, 7'd20,  7'd0,   7'd0,   7'd0,   1'b0, 8'd0};
    vecs[2]  = '{8'd34,  7'd30, 7'd20,  7'd20,  7'd20,  7'd20,  1'b0, 8'd1};
    vecs[3]  = '{8'd66,  7'd30, 7'd20,  7'd20,  7'd20,  7'd20,  1'b0, 8'd2};
    vecs[4]  = '{8'd64,  7'd8,  7'd20,  7'd20,  7'd20,  7'd20,  1'b1, 8'd2};
    vecs[5]  = '{8'd32,  7'd54, 7'd20,  7'd20,  7'd20,  7'd20,  1'b1, 8'd0};
    vecs[6]  = '{8'd31,  7'd8,  7'd20,  7'd20,  7'd20,  7'd20,  1'b1, 8'd0};
    vecs[7]  = '{8'd32,  7'd0,  7'd0,   7'd0,   7'd0,   7'd0,   1'b0, 8'd0};
    vecs[8]  = '{8'd34,  7'd30, 7'd0,   7'd0,   7'd0,   7'd0,   1'b0, 8'd0};
    vecs[9]  = '{8'd32,  7'd0,  7'd5,   7'd5,   7'd5,   7'd5,   1'b0, 8'd0};
    vecs[10] = '{8'd96,  7'd90, 7'd100, 7'd100, 7'd100, 7'd100, 1'b0, 8'd0};
    vecs[11] = '{8'd96,  7'd88, 7'd100, 7'd100, 7'd100, 7'd100, 1'b1, 8'd0};

    // Reset held while check and done_col are active.
    clr = 1'b0; check = 1'b1; done_col = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset busy", int'(busy), 0);
    cmp("reset result_valid", int'(result_valid), 0);
    cmp("reset hit", int'(hit), 0);
    cmp("reset score", int'(score), 0);
    cmp("reset game_over", int'(game_over), 0);
    @(negedge clk);
    check = 1'b0;
    clr = 1'b1;

    for (int i = 0; i < 12; i++) begin
      set_inputs(vecs[i].bx, vecs[i].by, vecs[i].op1, vecs[i].op2, vecs[i].op3, vecs[i].op4);
      run_check($sformatf("vec%0d", i));
      cmp($sformatf("vec%0d hit", i), int'(hit), int'(vecs[i].exp_hit));
      cmp($sformatf("vec%0d score", i), int'(score), int'(vecs[i].exp_score));
      cmp($sformatf("vec%0d game_over", i), int'(game_over), int'(vecs[i].exp_hit));
      if (vecs[i].exp_hit) begin
        expect_ignored($sformatf("vec%0d over", i));
        cmp($sformatf("vec%0d over_hit_held", i), int'(hit), 1);
        cmp($sformatf("vec%0d over_score_frozen", i), int'(score), int'(vecs[i].exp_score));
        do_reset();
      end
    end

    // done_col low: check ignored.
    do_reset();
    set_inputs(8'd10, 7'd50, 7'd20, 7'd40, 7'd60, 7'd80);
    @(negedge clk);
    done_col = 1'b0;
    expect_ignored("no_done_col");
    done_col = 1'b1;

    // check held during busy and REPORT gives exactly one result.
    begin
      int pulses;
      pulses = 0;
      set_inputs(8'd34, 7'd30, 7'd20, 7'd20, 7'd20, 7'd20);
      @(negedge clk);
      check = 1'b1;
      @(posedge clk);
      #1;
      for (int n = 1; n <= 12; n++) begin
        if (n == 6) check = 1'b0;
        @(posedge clk);
        #1;
        if (result_valid) pulses++;
      end
      check = 1'b0;
      cmp("reassert result pulses", pulses, 1);
      cmp("reassert score", int'(score), 1);
    end

    // Inputs changed mid-check: snapshot governs the result.
    set_inputs(8'd32, 7'd30, 7'd20, 7'd20, 7'd20, 7'd20);
    @(negedge clk);
    check = 1'b1;
    @(posedge clk);
    #1 check = 1'b0;
    col1_op = 7'd100; bird_y = 7'd0; done_col = 1'b0;
    begin
      int lat;
      lat = -1;
      for (int n = 1; n <= 10 && lat < 0; n++) begin
        @(posedge clk);
        #1;
        if (result_valid) lat = n;
      end
      cmp("snapshot latency", lat, 4);
    end
    @(posedge clk);
    #1;
    cmp("snapshot hit", int'(hit), 0);
    cmp("snapshot game_over", int'(game_over), 0);
    done_col = 1'b1;

    // Saturation: 254 passes, then two more.
    do_reset();
    set_inputs(8'd34, 7'd30, 7'd20, 7'd20, 7'd20, 7'd20);
    for (int i = 0; i < 254; i++) run_check("preload");
    cmp("preload score", int'(score), 254);
    run_check("sat1");
    cmp("sat1 score", int'(score), 255);
    run_check("sat2");
    cmp("sat2 score", int'(score), 255);
    cmp("sat2 hit", int'(hit), 0);

    // clr in CHECK k=2 with score 3.
    do_reset();
    for (int i = 0; i < 3; i++) run_check("pre_clr");
    cmp("pre_clr score", int'(score), 3);
    set_inputs(8'd10, 7'd50, 7'd20, 7'd20, 7'd20, 7'd20);
    @(negedge clk);
    check = 1'b1;
    @(posedge clk);
    #1 check = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 clr = 1'b0;
    #1;
    cmp("midclr busy", int'(busy), 0);
    cmp("midclr score", int'(score), 0);
    cmp("midclr result_valid", int'(result_valid), 0);
    cmp("midclr hit", int'(hit), 0);
    begin
      int seen;
      seen = 0;
      for (int n = 0; n < 6; n++) begin
        if (n == 2) clr = 1'b1;
        @(posedge clk);
        #1;
        if (result_valid) seen++;
      end
      cmp("midclr no result", seen, 0);
    end
    set_inputs(8'd34, 7'd30, 7'd20, 7'd20, 7'd20, 7'd20);
    run_check("post_clr");
    cmp("post_clr score", int'(score), 1);
    cmp("post_clr hit", int'(hit), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
